// File: rtl/ccff_stream_loader.sv
// ccff_stream_loader: serialises a valid/ready word stream MSB-first onto the config chain
// and checks a CRC-8 (poly 0x07) over every shifted bit against a trailing CRC word.
module ccff_stream_loader #(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              crc_err,
  output logic [CNT_W-1:0]  bit_count
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;
  localparam int NWORDS = CHAIN_LEN / DATA_W;
  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
  state_t state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, crc_q, crc_d;
  logic hold_vld_q, hold_vld_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d;
  logic shift, accept, fb;
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      crc_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      crc_q      <= crc_d;
    end
  end
  always_comb begin
    shift      = state_q == LOAD && hold_vld_q;
    accept     = in_valid && in_ready;
    fb         = crc_q[DATA_W-1] ^ hold_q[DATA_W-1];
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    crc_d      = crc_q;
    case (state_q)
      LOAD: begin
        if (shift) begin
          hold_d     = hold_q << 1;
          idx_d      = idx_q + 1'b1;
          cnt_d      = cnt_q + 1'b1;
          crc_d      = {crc_q[DATA_W-2:0], 1'b0} ^ (fb ? DATA_W'(8'h07) : '0);
          hold_vld_d = idx_q != LAST;
          state_d    = cnt_q == CNT_W'(CHAIN_LEN - 1) ? CHECK : LOAD;
        end
        // a new word may land in the same edge that shifts out bit 0 of the old one
        if (accept) begin
          hold_d     = in_data;
          hold_vld_d = 1'b1;
          idx_d      = '0;
          wcnt_d     = wcnt_q + 1'b1;
        end
      end
      CHECK: state_d = accept ? (in_data == crc_q ? DONE : ERR) : CHECK;
      default: if (start) begin
        state_d    = LOAD;
        hold_d     = '0;
        hold_vld_d = 1'b0;
        idx_d      = '0;
        cnt_d      = '0;
        wcnt_d     = '0;
        crc_d      = '0;
      end
    endcase
  end
  always_comb begin
    busy          = state_q == LOAD || state_q == CHECK;
    done          = state_q == DONE;
    crc_err       = state_q == ERR;
    in_ready      = state_q == CHECK ||
                    (state_q == LOAD && (!hold_vld_q || idx_q == LAST) && wcnt_q < CNT_W'(NWORDS));
    ccff_shift_en = hold_vld_q;
    ccff_head     = hold_q[DATA_W-1];
    bit_count     = cnt_q;
  end
endmodule

// File: doc/ccff_stream_loader.md
# ccff_stream_loader

Configuration-chain loader that sits directly upstream of the fabric's `ccff_head` input. It accepts configuration words over a valid/ready stream, serialises them MSB-first onto the chain, and asserts a per-bit shift enable for the chain flops. It accumulates a CRC-8 over every bit shifted, then checks the CRC against a trailing word so that a corrupted or tampered bitstream is flagged before the fabric is released.

## Interface
Parameters:
- `DATA_W`, default 8: stream word width; fixed at 8 because the CRC word is 8 bits.
- `CHAIN_LEN`, default 64: configuration-chain length in bits. Must be a non-zero multiple of `DATA_W`.
- `CNT_W`, default 16: bit-counter width. Must satisfy 2^`CNT_W` > `CHAIN_LEN`.

Ports:
- `prog_clk`, in, 1: programming clock.
- `pReset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to begin a load.
- `in_data`, in, `DATA_W`: configuration word, or the CRC word at the end of the stream.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the loader accepts `in_data` this cycle.
- `ccff_head`, out, 1: serial bit to the chain head.
- `ccff_shift_en`, out, 1: the chain shifts on this `prog_clk` edge.
- `busy`, out, 1: state is LOAD or CHECK.
- `done`, out, 1: load completed and the CRC matched.
- `crc_err`, out, 1: load completed and the CRC mismatched.
- `bit_count`, out, `CNT_W`: number of bits shifted so far.

## Operation
- States are IDLE, LOAD, CHECK, DONE and ERR.
- Reset values: state IDLE; all outputs 0; CRC register 0x00; holding register empty.
- IDLE/DONE/ERR + `start` → LOAD.
  - Clears `bit_count`, the CRC register, `done` and `crc_err`.
  - `start` is ignored in LOAD and CHECK.
- LOAD, word handling:
  - A word is accepted when `in_valid && in_ready`.
  - The accepted word is loaded into the holding shift register with bit index 0 set to 0.
  - `in_ready` = (holding register empty OR last bit of the current word is shifting this cycle) AND words remaining > 0.
  - Words remaining = `CHAIN_LEN`/`DATA_W` − words accepted.
- LOAD, per shifted bit:
  - While the holding register is non-empty: `ccff_shift_en`=1 and `ccff_head` = current MSB.
  - The holding register shifts left.
  - `bit_count` increments.
  - The CRC is updated.
- CRC-8 rules:
  - Polynomial x^8+x^2+x+1 (0x07), initial value 0x00, MSB-first, no reflection, no final XOR.
  - Per bit: fb = crc[7] ^ bit; crc = {crc[6:0],1'b0} ^ (fb ? 0x07 : 0x00).
- Input stall: when the holding register is empty, `ccff_shift_en`=0 and `ccff_head`=0. The chain holds its state; there are no gaps in data, only in time.
- LOAD → CHECK on the cycle the bit with `bit_count`=`CHAIN_LEN`−1 shifts. After the transition, `ccff_shift_en` is never asserted again until the next `start`.
- CHECK:
  - `in_ready`=1; the next accepted word is the expected CRC.
  - Equal to the CRC register → DONE, `done`=1.
  - Not equal → ERR, `crc_err`=1.
- DONE/ERR: flags and `bit_count` hold until `start` or reset.
- `in_ready`=0 in IDLE, DONE and ERR. Words offered in those states are not consumed.
- Reset mid-load: all state clears asynchronously and `ccff_shift_en` drops immediately. Chain contents are undefined; software must reload.

## Timing
- `start` at edge t: `busy`=1 and `in_ready`=1 from cycle t+1.
- Word accepted at edge a: bit 7 appears on `ccff_head` with `ccff_shift_en`=1 in cycle a+1, and bit 0 in cycle a+8.
- A back-to-back word is accepted at edge a+8 (during its bit-0 cycle), giving continuous shifting at 1 bit/cycle.
- A full load of N=`CHAIN_LEN` bits with no stalls takes N cycles of shift.
- CRC word accepted at edge c: `done` or `crc_err` rises at t=c+1, and `busy` falls in the same cycle.
- All outputs are registered except `in_ready`, which is combinational from state and holding-register status only. It never depends on `in_valid`.

## Test plan
- Reset check: assert `pReset`=0 mid-LOAD at bit 20 → next cycle all outputs are 0 and state is IDLE. A new `start` reloads cleanly.
- Zero stream, defaults: 8 × 0x00 then CRC 0x00 → exactly 64 cycles with `ccff_shift_en`=1 and `ccff_head`=0, then `done`=1, `crc_err`=0, `bit_count`=64.
- Single set bit: 7 × 0x00, 0x01, then CRC 0x07 → `done`=1. The same stream with CRC 0x08 → `crc_err`=1, `done`=0.
- Standard check vector, `CHAIN_LEN`=72: ASCII "123456789", then 0xF4 → `done`=1. The `ccff_head` sequence equals 0x31 MSB-first, then 0x32 MSB-first, and so on.
- Stalls: `in_valid` toggled randomly with a 50% duty cycle → serial bit order is unchanged, and `ccff_shift_en` is low exactly during empty-holding cycles. Total shifted bits = 64; `done`=1.
- Protocol edges: `start` pulsed during LOAD is ignored. Words offered in IDLE and DONE are not consumed (`in_ready`=0). After ERR, a second `start` plus a correct stream → `done`=1 and `crc_err`=0.
